// File: rtl/num_ram_pkg.sv
// Shared types for the number-RAM read and write paths: address/word widths,
// and the read controller's state encoding.
package num_ram_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

    typedef logic [ADDR_W-1:0]        addr_t;
    typedef logic signed [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } rd_state_t;

endpackage

// File: rtl/data_read_controller_if.sv
// Bundle of the read controller's control, RAM-read and output-stream signals.
// master is the controller side, slave is the RAM/stream/sequencer side.
interface data_read_controller_if;
    import num_ram_pkg::*;

    logic  start;
    addr_t total_count;
    logic  ram_rd_en;
    addr_t ram_rd_addr;
    word_t ram_rd_data;
    word_t out_data;
    logic  out_valid;
    logic  out_ready;
    logic  busy;
    addr_t read_count;
    logic  done;

    modport master (
        input  start, total_count, ram_rd_data, out_ready,
        output ram_rd_en, ram_rd_addr, out_data, out_valid, busy, read_count, done
    );

    modport slave (
        output start, total_count, ram_rd_data, out_ready,
        input  ram_rd_en, ram_rd_addr, out_data, out_valid, busy, read_count, done
    );

endinterface

// File: rtl/rd_skid_fifo.sv
// Two-entry first-word-fall-through buffer between the RAM read pipe and the
// output stream. A push into an empty buffer becomes visible the next cycle.
module rd_skid_fifo
    import num_ram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  word_t      push_data_i,
    input  logic       pop_i,
    output word_t      head_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [1:0] count_o
);

    word_t      mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       do_push;
    logic       do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // NOTE: the storage array has no reset; head_o is masked while empty so stale contents never leak out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= !wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 2'd1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 2'd1;
            end
        end
    end

endmodule

// File: rtl/data_read_controller.sv
// Streams words 0..count-1 from the number RAM onto a valid/ready stream,
// holding at most two words outstanding (in flight plus buffered).
module data_read_controller
    import num_ram_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input logic                    clk,
    input logic                    rst_n,
    data_read_controller_if.master bus
);

    rd_state_t             state_q, state_d;
    addr_t                 count_q, count_d;
    addr_t                 issue_addr_q, issue_addr_d;
    addr_t                 read_count_q, read_count_d;
    addr_t                 rd_addr_q, rd_addr_d;
    logic                  rd_en_q, rd_en_d;
    logic [RD_LATENCY-1:0] pipe_q;

    logic       fifo_push;
    logic       fifo_full;
    logic       fifo_empty;
    logic [1:0] fifo_cnt;
    logic [2:0] inflight;
    logic [2:0] credit_used;
    logic       xfer;

    assign fifo_push = pipe_q[RD_LATENCY-1];
    assign xfer      = !fifo_empty && bus.out_ready;

    rd_skid_fifo u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i (bus.ram_rd_data),
        .pop_i       (xfer),
        .head_o      (bus.out_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_cnt)
    );

    // Registered occupancy only: a word popped this cycle frees its slot next cycle.
    always_comb begin
        inflight = {2'b00, rd_en_q};
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + {2'b00, pipe_q[i]};
        end
        credit_used = inflight + {1'b0, fifo_cnt};
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        issue_addr_d = issue_addr_q;
        read_count_d = read_count_q;
        rd_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    count_d      = bus.total_count;
                    issue_addr_d = '0;
                    read_count_d = '0;
                    state_d      = (bus.total_count == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                if (issue_addr_q < count_q && credit_used < 3'd2 && !fifo_full) begin
                    rd_en_d      = 1'b1;
                    rd_addr_d    = issue_addr_q;
                    issue_addr_d = issue_addr_q + addr_t'(1);
                end
                if (xfer) begin
                    read_count_d = read_count_q + addr_t'(1);
                    if (read_count_d == count_q) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            issue_addr_q <= '0;
            read_count_q <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            pipe_q       <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            issue_addr_q <= issue_addr_d;
            read_count_q <= read_count_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            pipe_q[0]    <= rd_en_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign bus.ram_rd_en   = rd_en_q;
    assign bus.ram_rd_addr = rd_addr_q;
    assign bus.out_valid   = !fifo_empty;
    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == FINISH);
    assign bus.read_count  = read_count_q;

endmodule
